// File: rtl/fft_pkg.sv
// Shared FFT constants and number-format helpers (sign-magnitude <-> two's complement, saturation).
// Helpers work on a 64-bit container so one copy serves any sample width up to 31 bits.
package fft_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SHIFT = 8;
    localparam int MAXW      = 64;

    typedef logic [MAXW-1:0] wide_t;
    typedef logic [5:0]      wid_t;

    // Sign-magnitude of width w (zero-extended in v) to two's complement; negative zero maps to 0.
    function automatic logic signed [MAXW-1:0] sm2tc(input wide_t v, input wid_t w);
        wide_t mask;
        wide_t mag;
        mask = (wide_t'(1) << (w - 6'd1)) - wide_t'(1);
        mag  = v & mask;
        if (v[w - 6'd1]) begin
            return -$signed(mag);
        end else begin
            return $signed(mag);
        end
    endfunction

    // Two's complement to width-w sign-magnitude, clamped to +/-(2^(w-1)-1); zero always has sign 0.
    function automatic wide_t sat2sm(input logic signed [MAXW-1:0] x, input wid_t w);
        logic signed [MAXW-1:0] lim;
        wide_t                  mag;
        logic                   neg;
        lim = $signed((wide_t'(1) << (w - 6'd1)) - wide_t'(1));
        neg = 1'b0;
        if (x > lim) begin
            mag = lim;
        end else if (x < -lim) begin
            mag = lim;
            neg = 1'b1;
        end else if (x < 64'sd0) begin
            mag = -x;
            neg = 1'b1;
        end else begin
            mag = x;
        end
        return mag | (wide_t'(neg) << (w - 6'd1));
    endfunction

endpackage

// File: rtl/ipe_cmul_conj.sv
// Two-stage pipelined multiply by conj(W) with floor shift; bypass passes (y2, y3) through unrotated.
module cmul_conj
    import fft_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic signed [WIDTH-1:0]   i_y2,
    input  logic signed [WIDTH-1:0]   i_y3,
    input  logic signed [WIDTH-1:0]   i_tfr,
    input  logic signed [WIDTH-1:0]   i_tfi,
    input  logic                      i_byp_n,
    output logic signed [2*WIDTH:0]   o_pr,
    output logic signed [2*WIDTH:0]   o_pi
);

    localparam int MW = 2 * WIDTH;
    localparam int PW = 2 * WIDTH + 1;

    logic signed [MW-1:0] r_y2_tr, r_y3_ti, r_y3_tr, r_y2_ti;
    logic signed [WIDTH-1:0] r_y2, r_y3;
    logic                    r_byp_n;
    logic signed [PW-1:0]    r_pr, r_pi;
    logic signed [PW-1:0]    w_sum_r, w_sum_i;

    // Product stage: the four partial products plus the raw operands for the bypass path.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_y2_tr <= '0;
            r_y3_ti <= '0;
            r_y3_tr <= '0;
            r_y2_ti <= '0;
            r_y2    <= '0;
            r_y3    <= '0;
            r_byp_n <= 1'b0;
        end else begin
            r_y2_tr <= MW'(i_y2) * MW'(i_tfr);
            r_y3_ti <= MW'(i_y3) * MW'(i_tfi);
            r_y3_tr <= MW'(i_y3) * MW'(i_tfr);
            r_y2_ti <= MW'(i_y2) * MW'(i_tfi);
            r_y2    <= i_y2;
            r_y3    <= i_y3;
            r_byp_n <= i_byp_n;
        end
    end

    assign w_sum_r = PW'(r_y2_tr) + PW'(r_y3_ti);
    assign w_sum_i = PW'(r_y3_tr) - PW'(r_y2_ti);

    // Sum stage: arithmetic shift floors toward minus infinity on the full-width sum.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pr <= '0;
            r_pi <= '0;
        end else if (r_byp_n) begin
            r_pr <= w_sum_r >>> SHIFT;
            r_pi <= w_sum_i >>> SHIFT;
        end else begin
            r_pr <= PW'(r_y2);
            r_pi <= PW'(r_y3);
        end
    end

    assign o_pr = r_pr;
    assign o_pi = r_pi;

endmodule

// File: rtl/ipe.sv
// Inverse radix-2x2 processing element: rotate (y2, y3) by conj(W), then add/sub against (y0, y1).
// Five register stages, one sample per cycle, sign-magnitude in and out.
module ipe
    import fft_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic [WIDTH-1:0]     in3,
    input  logic [2*WIDTH-1:0]   tf,
    input  logic                 bypass_n,
    input  logic                 in_valid,
    output logic [WIDTH-1:0]     out0,
    output logic [WIDTH-1:0]     out1,
    output logic [WIDTH-1:0]     out2,
    output logic [WIDTH-1:0]     out3,
    output logic                 out_valid
);

    localparam int PW = 2 * WIDTH + 1;
    localparam int XW = PW + 1;

    logic [WIDTH-1:0]        w_in [4];
    logic signed [MAXW-1:0]  w_tc_wide [6];
    logic signed [WIDTH-1:0] w_tc [6];

    logic signed [WIDTH-1:0] r1_y [4];
    logic signed [WIDTH-1:0] r1_tfr, r1_tfi;
    logic                    r1_byp_n;
    logic signed [WIDTH-1:0] r2_y0, r2_y1, r3_y0, r3_y1;
    logic signed [PW-1:0]    w_pr, w_pi;
    logic signed [XW-1:0]    r4_x [4];
    wide_t                   w_sm_wide [4];
    logic [WIDTH-1:0]        w_sm [4];
    logic [WIDTH-1:0]        r_out [4];
    logic [4:0]              r_valid;

    assign w_in[0] = in0;
    assign w_in[1] = in1;
    assign w_in[2] = in2;
    assign w_in[3] = in3;

    // Input format conversion: four samples then tf_r, tf_i.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_tc_wide[i] = sm2tc(wide_t'(w_in[i]), wid_t'(WIDTH));
        end
        w_tc_wide[4] = sm2tc(wide_t'(tf[2*WIDTH-1:WIDTH]), wid_t'(WIDTH));
        w_tc_wide[5] = sm2tc(wide_t'(tf[WIDTH-1:0]), wid_t'(WIDTH));
        for (int i = 0; i < 6; i++) begin
            w_tc[i] = w_tc_wide[i][WIDTH-1:0];
        end
    end

    // Stage 1 capture plus the y0/y1 delay line that tracks the two multiplier stages.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                r1_y[i] <= '0;
            end
            r1_tfr   <= '0;
            r1_tfi   <= '0;
            r1_byp_n <= 1'b0;
            r2_y0    <= '0;
            r2_y1    <= '0;
            r3_y0    <= '0;
            r3_y1    <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r1_y[i] <= w_tc[i];
            end
            r1_tfr   <= w_tc[4];
            r1_tfi   <= w_tc[5];
            r1_byp_n <= bypass_n;
            r2_y0    <= r1_y[0];
            r2_y1    <= r1_y[1];
            r3_y0    <= r2_y0;
            r3_y1    <= r2_y1;
        end
    end

    cmul_conj #(
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
    ) u_cmul (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_y2    (r1_y[2]),
        .i_y3    (r1_y[3]),
        .i_tfr   (r1_tfr),
        .i_tfi   (r1_tfi),
        .i_byp_n (r1_byp_n),
        .o_pr    (w_pr),
        .o_pi    (w_pi)
    );

    // Stage 4: full-precision butterfly, saturation deferred to the next stage.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                r4_x[i] <= '0;
            end
        end else begin
            r4_x[0] <= XW'(r3_y0) + XW'(w_pr);
            r4_x[1] <= XW'(r3_y0) - XW'(w_pr);
            r4_x[2] <= XW'(r3_y1) + XW'(w_pi);
            r4_x[3] <= XW'(r3_y1) - XW'(w_pi);
        end
    end

    // Saturate and convert each butterfly result back to sign-magnitude.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_sm_wide[i] = sat2sm(MAXW'(r4_x[i]), wid_t'(WIDTH));
            w_sm[i]      = w_sm_wide[i][WIDTH-1:0];
        end
    end

    // Stage 5: output registers load only with a valid sample so they hold across bubbles.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                r_out[i] <= '0;
            end
            r_valid <= 5'd0;
        end else begin
            if (r_valid[3]) begin
                for (int i = 0; i < 4; i++) begin
                    r_out[i] <= w_sm[i];
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    r_out[i] <= r_out[i];
                end
            end
            r_valid <= {r_valid[3:0], in_valid};
        end
    end

    assign out0      = r_out[0];
    assign out1      = r_out[1];
    assign out2      = r_out[2];
    assign out3      = r_out[3];
    assign out_valid = r_valid[4];

endmodule

// File: tb/tb_ipe.sv
// Scoreboard bench for ipe: stimulus pushes expected outputs, a negedge monitor pops on out_valid.
module tb_ipe;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] in0, in1, in2, in3;
    logic [31:0] tf;
    logic        bypass_n;
    logic        in_valid;
    logic [15:0] out0, out1, out2, out3;
    logic        out_valid;

    typedef struct {
        logic [63:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [63:0] last_exp = 64'd0;

    ipe dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .tf        (tf),
        .bypass_n  (bypass_n),
        .in_valid  (in_valid),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic longint smv(input logic [15:0] v);
        longint m;
        m = longint'(v[14:0]);
        return v[15] ? -m : m;
    endfunction

    function automatic logic [15:0] tosm(input longint x);
        if (x > 32767) x = 32767;
        if (x < -32767) x = -32767;
        return (x < 0) ? {1'b1, 15'(-x)} : {1'b0, 15'(x)};
    endfunction

    // Reference for the vectors not worked out by hand.
    function automatic logic [63:0] model(input logic [15:0] a, b, c, d,
                                          input logic [31:0] t, input logic bn);
        longint y0, y1, y2, y3, tr, ti, pr, pi;
        logic [15:0] th, tl;
        th = t[31:16];
        tl = t[15:0];
        y0 = smv(a); y1 = smv(b); y2 = smv(c); y3 = smv(d);
        tr = smv(th); ti = smv(tl);
        if (bn) begin
            pr = (y2 * tr + y3 * ti) >>> 8;
            pi = (y3 * tr - y2 * ti) >>> 8;
        end else begin
            pr = y2;
            pi = y3;
        end
        return {tosm(y0 + pr), tosm(y0 - pr), tosm(y1 + pi), tosm(y1 - pi)};
    endfunction

    task automatic drive(input logic [15:0] a, b, c, d, input logic [31:0] t, input logic bn);
        in0 = a; in1 = b; in2 = c; in3 = d; tf = t; bypass_n = bn; in_valid = 1'b1;
    endtask

    task automatic send(input logic [15:0] a, b, c, d, input logic [31:0] t, input logic bn,
                        input logic [63:0] e, input string nm);
        @(negedge Clk);
        Reset = 1'b0;
        drive(a, b, c, d, t, bn);
        q.push_back('{e, cyc + 5, nm});
        last_exp = e;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge Clk);
            Reset    = 1'b0;
            in_valid = 1'b0;
        end
    endtask

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp_v);
        end
    endtask

    // Monitor: every out_valid must match the oldest expectation, both data and arrival cycle.
    always @(negedge Clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid at cycle %0d got=%h expected=no output",
                         cyc, {out0, out1, out2, out3});
            end else begin
                e = q.pop_front();
                check64({e.name, "_data"}, {out0, out1, out2, out3}, e.data);
                checks++;
                if (cyc != e.cyc) begin
                    failures++;
                    $display("FAIL %s_latency got cycle=%0d expected cycle=%0d", e.name, cyc, e.cyc);
                end
            end
        end
    end

    localparam logic [31:0] W_ONE = {16'd256, 16'd0};
    localparam logic [31:0] W_J   = {16'd0, 16'd256};

    initial begin
        logic [15:0] ra, rb, rc, rd;
        logic [31:0] rt;
        logic        rbn;

        Reset = 1'b1; in_valid = 1'b0; bypass_n = 1'b1;
        in0 = 16'd0; in1 = 16'd0; in2 = 16'd0; in3 = 16'd0; tf = 32'd0;
        repeat (3) @(negedge Clk);
        check64("reset_state", {out0, out1, out2, out3, 63'd0, out_valid}, 128'd0);

        // Hand-computed directed vectors; the first one leaves reset in the same cycle.
        send(16'd10, 16'd3, 16'd4, 16'd5, W_ONE, 1'b1, {16'd14, 16'd6, 16'd8, 16'h8002}, "identity");
        idle(6);
        send(16'd10, 16'd3, 16'd4, 16'd5, W_J, 1'b1, {16'd15, 16'd5, 16'h8001, 16'd7}, "w_j");
        send(16'h7FFF, 16'd0, 16'd1, 16'd0, W_ONE, 1'b1, {16'h7FFF, 16'h7FFE, 16'd0, 16'd0}, "saturate");
        send(16'd10, 16'd3, 16'd4, 16'd5, 32'hFFFFFFFF, 1'b0, {16'd14, 16'd6, 16'd8, 16'h8002}, "bypass");
        send(16'd0, 16'd0, 16'h8000, 16'd0, W_ONE, 1'b1, 64'd0, "neg_zero");
        send(16'd0, 16'd0, 16'h8001, 16'd0, {16'd128, 16'd0}, 1'b1, {16'h8001, 16'd1, 16'd0, 16'd0}, "floor_shift");
        send(16'h8000, 16'h8000, 16'h8000, 16'h8000, W_J, 1'b1, 64'd0, "all_neg_zero");
        send(16'h8005, 16'd7, 16'h7FFF, 16'h7FFF, 32'h80008000, 1'b1, {16'h8005, 16'h8005, 16'd7, 16'd7}, "zero_tf");
        idle(7);

        // Bypass toggling every sample against the reference.
        for (int i = 0; i < 8; i++) begin
            ra  = 16'(100 + 37 * i);
            rb  = 16'h8000 | 16'(50 * i + 9);
            rc  = (i % 3 == 0) ? 16'h8000 | 16'(1200 + i) : 16'(3000 - 111 * i);
            rd  = 16'(17 * i + 5);
            rt  = {16'(181 + 10 * i), 16'h8000 | 16'(181 - 7 * i)};
            rbn = i[0];
            send(ra, rb, rc, rd, rt, rbn, model(ra, rb, rc, rd, rt, rbn), $sformatf("interleave%0d", i));
        end
        idle(7);

        // Reset in the middle of a stream: earlier samples must vanish, later ones flow.
        for (int i = 0; i < 8; i++) begin
            ra  = 16'(1000 * i + 1);
            rb  = 16'h8000 | 16'(300 + i);
            rc  = 16'(2000 + 40 * i);
            rd  = 16'h8000 | 16'(77 * i);
            rt  = {16'h8000 | 16'(90 + i), 16'(220 - i)};
            rbn = 1'b1;
            @(negedge Clk);
            if (i == 4) begin
                check64("post_reset_clear", {out0, out1, out2, out3, 63'd0, out_valid}, 128'd0);
            end
            drive(ra, rb, rc, rd, rt, rbn);
            if (i == 3) begin
                Reset = 1'b1;
                q.delete();
            end else begin
                Reset = 1'b0;
                q.push_back('{model(ra, rb, rc, rd, rt, rbn), cyc + 5, $sformatf("post_reset%0d", i)});
                last_exp = model(ra, rb, rc, rd, rt, rbn);
            end
        end
        idle(12);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending expected=0 pending", q.size());
        end
        check64("hold_after_idle", {out0, out1, out2, out3, 63'd0, out_valid}, {last_exp, 64'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ipe.md
IPE -- requirements
Module: ipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample width in sign-magnitude (bit WIDTH-1 sign, lower bits magnitude).
REQ-002 SHALL have parameter SHIFT, default 8: number of twiddle fractional bits (1.0 = 2^SHIFT).
REQ-003 SHALL have one clock and a synchronous active-high reset: port Clk, input, 1 bit, rising-edge clock.
REQ-004 SHALL have port Reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have ports in0, in1, in2 and in3, input, WIDTH each, sign-magnitude forward-butterfly outputs y0..y3.
REQ-006 SHALL have port tf, input, 2*WIDTH: {tf_r, tf_i}, sign-magnitude twiddle W.
REQ-007 SHALL have port bypass_n, input, 1 bit: 0 = no rotation.
REQ-008 SHALL have port in_valid, input, 1 bit: qualifies in*, tf and bypass_n in the same cycle.
REQ-009 SHALL have ports out0, out1, out2 and out3, output, WIDTH each, sign-magnitude results x0..x3.
REQ-010 SHALL have port out_valid, output, 1 bit: qualifies out*.

Function
REQ-011 SHALL convert inputs to two's complement; a negative zero (sign 1, magnitude 0) SHALL be treated as 0.
REQ-012 SHALL form the rotation p = (y2 + j*y3)*conj(W): p_r = (y2*tf_r + y3*tf_i) >>> SHIFT, p_i = (y3*tf_r - y2*tf_i) >>> SHIFT, using an arithmetic (floor) shift on the full-width sum.
REQ-013 SHALL use p_r = y2 and p_i = y3 when bypass_n = 0, ignoring tf, with latency unchanged.
REQ-014 SHALL compute x0 = y0 + p_r, x1 = y0 - p_r, x2 = y1 + p_i and x3 = y1 - p_i.
REQ-015 SHALL size intermediates with no overflow: products 2*WIDTH bits, p sum 2*WIDTH+1 bits, and final add/sub done before saturation.
REQ-016 SHALL saturate each result to ±(2^(WIDTH-1)-1), then convert to sign-magnitude; a zero result SHALL be output with sign 0.
REQ-017 SHALL be a 5-stage pipeline: (1) register and convert to two's complement; (2) four products; (3) p_r/p_i sum and shift; (4) add/sub; (5) saturate and convert to sign-magnitude into the output registers.
REQ-018 SHALL have fixed latency: in_valid at edge N gives out_valid and data at edge N+5.
REQ-019 SHALL accept a new sample every cycle (throughput 1 per cycle), with no backpressure.
REQ-020 SHALL carry bypass_n down the pipeline with its sample, so a change mid-stream affects only that sample.
REQ-021 SHALL carry in_valid down a 5-bit valid shift register that drives out_valid.
REQ-022 SHALL hold out* at their last values while out_valid = 0; data registers SHALL NOT be gated by valid.

Reset
REQ-023 SHALL, on Reset = 1 at a rising edge, clear all pipeline registers, out0..out3 and out_valid to 0.
REQ-024 SHALL drop samples in flight when reset is asserted mid-stream; out_valid SHALL be 0 for at least 5 cycles after reset deassertion unless in_valid is asserted.
REQ-025 SHALL sample in_valid on the first edge with Reset = 0.

Structure
REQ-026 SHALL place the sign-magnitude <-> two's-complement conversion and saturation helpers in shared package fft_pkg, for reuse with pe.
REQ-027 SHALL place the default WIDTH/SHIFT constants in fft_pkg.
REQ-028 SHALL have one natural sub-module, cmul_conj: stages 2-3, a pipelined conjugate complex multiply with shift.

Verification (WIDTH = 16, SHIFT = 8; values are decimal and sign-magnitude)
REQ-029 SHALL cover identity W: tf_r = 256, tf_i = 0, in = (10, 3, 4, 5) -> out = (14, 6, 8, 0x8002) exactly 5 cycles later, out_valid = 1 for one cycle.
REQ-030 SHALL cover W = j: tf_r = 0, tf_i = 256, in = (10, 3, 4, 5) -> p = (5, -4) -> out = (15, 5, 0x8001, 7).
REQ-031 SHALL cover saturation and zero sign: in0 = 0x7FFF, in1 = 0, in2 = 1, in3 = 0, W = 1.0 -> out0 = 0x7FFF, out1 = 0x7FFE, out2 = 0, out3 = 0 (no 0x8000).
REQ-032 SHALL cover bypass: bypass_n = 0, tf = 0xFFFFFFFF, in = (10, 3, 4, 5) -> out = (14, 6, 8, 0x8002); interleaving bypass_n = 1/0 per cycle matches the per-sample model.
REQ-033 SHALL cover reset mid-stream: 8 back-to-back valid samples, Reset at cycle 3 for 1 cycle -> all outputs 0, no out_valid for pre-reset samples.
REQ-034 SHALL cover negative-zero and floor shift: in2 = 0x8000, W = 1.0 gives p_r = 0; in2 = 0x8001, tf_r = 128 gives p_r = -1 (floor of -0.5).
